// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with valid/ready input
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 RTS,
    input  logic                 BaudTick,
    output logic                 TxD_ser,
    output logic                 tx_busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of 2, at least 2");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] load_data;
    logic [3:0]           cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 txd_q, line_d;
    logic                 busy_q, busy_d;
    logic                 last_stop, can_start, load, queued;

    // The last stop tick is already baud-aligned, so a new frame may start there.
    assign last_stop = (state_q == S_STOP) && (cnt_q == LAST_STOP) && BaudTick;
    assign can_start = RTS && ((state_q == S_IDLE) || last_stop);

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign push       = tx_valid && !fifo_full;
    assign pop        = can_start && !fifo_empty;
    assign tx_ready   = !fifo_full;
    assign load       = pop;
    assign load_data  = fifo_mem[rd_ptr_q];
    assign queued     = !fifo_empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= tx_data;
    end
`else
    assign tx_ready  = can_start;
    assign load      = tx_valid && can_start;
    assign load_data = tx_data;
    assign queued    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_SYNC: begin
                if (BaudTick) state_d = S_START;
            end
            S_START: begin
                if (BaudTick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (BaudTick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (BaudTick) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (BaudTick) begin
                    if (cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
        if (load) begin
            shift_d = load_data;
            par_d   = (PARITY == 2) ? (^load_data) : ~(^load_data);
            cnt_d   = '0;
            state_d = (state_q == S_IDLE) ? S_SYNC : S_START;
        end
    end

    // Line and busy are derived from the current state and register one clock later.
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_q[0];
            S_PAR:   line_d = par_q;
            default: line_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || queued;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            txd_q   <= line_d;
            busy_q  <= busy_d;
        end
    end

    assign TxD_ser = txd_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param (8N1 model plus a 7E2 instance)
module tb_uart_tx_param;

    localparam int A_DB   = 8;
    localparam int A_PAR  = 0;
    localparam int A_STOP = 1;
    localparam int FD     = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       RTS = 1'b1;
    logic       BaudTick = 1'b0;
    logic       TxD_ser;
    logic       tx_busy;

    logic [6:0] tx_data_b = '0;
    logic       tx_valid_b = 1'b0;
    logic       tx_ready_b;
    logic       TxD_b;
    logic       tx_busy_b;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;

    uart_tx_param #(.DATA_BITS(A_DB), .PARITY(A_PAR), .STOP_BITS(A_STOP), .FIFO_DEPTH(FD)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .RTS(RTS), .BaudTick(BaudTick), .TxD_ser(TxD_ser), .tx_busy(tx_busy)
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(FD)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .RTS(RTS), .BaudTick(BaudTick), .TxD_ser(TxD_b), .tx_busy(tx_busy_b)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            tick_cnt++;
            BaudTick = (tick_cnt % 16 == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each frame is a queue of line levels, one per baud period.
    int   frame[$];
    bit   m_active = 1'b0;
    bit   m_wait   = 1'b0;
    logic exp_line = 1'b1;
    logic exp_busy = 1'b0;
`ifdef UART_TX_FIFO_EN
    int   fq[$];
`endif

    function automatic bit start_ok();
        return RTS && (!m_active || (!m_wait && frame.size() == 1 && BaudTick));
    endfunction

    function automatic bit model_ready();
`ifdef UART_TX_FIFO_EN
        return fq.size() < FD;
`else
        return start_ok();
`endif
    endfunction

    function automatic void load_frame(input int w);
        int p;
        p = 0;
        frame.delete();
        frame.push_back(0);
        for (int i = 0; i < A_DB; i++) begin
            frame.push_back((w >> i) & 1);
            p = p ^ ((w >> i) & 1);
        end
        if (A_PAR != 0) frame.push_back((A_PAR == 1) ? (p ^ 1) : p);
        for (int i = 0; i < A_STOP; i++) frame.push_back(1);
    endfunction

    initial begin
        bit go;
        bit was_idle;
        int word;
`ifdef UART_TX_FIFO_EN
        bit push;
`endif
        forever begin
            @(posedge sys_clk or posedge sys_rst);
            if (sys_rst) begin
                frame.delete();
                m_active = 1'b0;
                m_wait   = 1'b0;
                exp_line = 1'b1;
                exp_busy = 1'b0;
`ifdef UART_TX_FIFO_EN
                fq.delete();
`endif
            end else begin
                was_idle = !m_active;
`ifdef UART_TX_FIFO_EN
                go       = start_ok() && (fq.size() > 0);
                push     = tx_valid && (fq.size() < FD);
                exp_busy = m_active || (fq.size() > 0);
`else
                go       = start_ok() && tx_valid;
                exp_busy = m_active;
`endif
                exp_line = (m_active && !m_wait) ? (frame[0] != 0) : 1'b1;
                if (BaudTick && m_active) begin
                    if (m_wait) begin
                        m_wait = 1'b0;
                    end else begin
                        void'(frame.pop_front());
                        if (frame.size() == 0) m_active = 1'b0;
                    end
                end
                if (go) begin
`ifdef UART_TX_FIFO_EN
                    word = fq.pop_front();
`else
                    word = int'(tx_data);
`endif
                    load_frame(word);
                    m_active = 1'b1;
                    m_wait   = was_idle;
                end
`ifdef UART_TX_FIFO_EN
                if (push) fq.push_back(int'(tx_data));
`endif
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            check("ready_vs_model", tx_ready, model_ready());
            check("txd_vs_model", TxD_ser, exp_line);
            check("busy_vs_model", tx_busy, exp_busy);
        end
    end

    function automatic logic line_of(input bit use_b);
        return use_b ? TxD_b : TxD_ser;
    endfunction

    task automatic wait_ready(input bit use_b, input string name);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 2000) begin
            @(negedge sys_clk);
            t++;
            ok = use_b ? tx_ready_b : tx_ready;
        end
        check(name, ok, 1'b1);
        @(posedge sys_clk);
        #2;
    endtask

    task automatic send(input bit use_b, input logic [7:0] d, input string name);
        @(posedge sys_clk);
        #2;
        if (use_b) begin
            tx_data_b  = d[6:0];
            tx_valid_b = 1'b1;
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
        end
        wait_ready(use_b, name);
        if (use_b) tx_valid_b = 1'b0;
        else       tx_valid   = 1'b0;
    endtask

    task automatic wait_line(input bit use_b, input logic val, output int n);
        n = 0;
        while (line_of(use_b) !== val && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
    endtask

    task automatic sample_frame(input bit use_b, input logic [63:0] exp, input int nbits, input string name);
        int n;
        wait_line(use_b, 1'b0, n);
        check({name, "_start_seen"}, (n < 4000), 1'b1);
        repeat (8) @(negedge sys_clk);
        for (int i = 0; i < nbits; i++) begin
            check(name, line_of(use_b), exp[i]);
            repeat (16) @(negedge sys_clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((tx_busy || tx_busy_b) && t < 4000) begin
            @(negedge sys_clk);
            t++;
        end
        check(name, (t < 4000), 1'b1);
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic send_pair();
        @(posedge sys_clk);
        #2;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_ready(1'b0, "pair_first_accept");
        tx_data = 8'hFF;
        wait_ready(1'b0, "pair_second_accept");
        tx_valid = 1'b0;
    endtask

    task automatic measure_gap();
        int a, b, c;
        wait_line(1'b0, 1'b0, a);
        wait_line(1'b0, 1'b1, b);
        wait_line(1'b0, 1'b0, c);
        check("b2b_start_to_start_clks", b + c, 160);
        check("b2b_first_start_seen", (a < 4000), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, bad;
        RTS = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        check("reset_txd", TxD_ser, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_txd_b", TxD_b, 1'b1);
        check("reset_busy_b", tx_busy_b, 1'b0);
        sys_rst = 1'b0;
        repeat (10) @(posedge sys_clk);

        // 0xA5 on 8N1 and 0x53 on 7E2; frames packed LSB = first bit on the line
        fork
            begin
                send(1'b0, 8'hA5, "accept_a5");
                sample_frame(1'b0, 64'h34A, 10, "frame_a5_8n1");
            end
            begin
                send(1'b1, 8'h53, "accept_53");
                sample_frame(1'b1, 64'h6A6, 11, "frame_53_7e2");
            end
        join
        wait_idle("idle_after_t1");

        fork
            send_pair();
            measure_gap();
        join
        wait_idle("idle_after_pair");

`ifndef UART_TX_FIFO_EN
        @(posedge sys_clk);
        #2;
        RTS      = 1'b0;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        acc = 0;
        bad = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (tx_ready) acc++;
            if (TxD_ser !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("rts_low_accepts", acc, 0);
        check("rts_low_line_idle", bad, 0);
        @(posedge sys_clk);
        #2;
        RTS = 1'b1;
        @(negedge sys_clk);
        check("rts_rise_ready", tx_ready, 1'b1);
        @(posedge sys_clk);
        #2;
        tx_valid = 1'b0;
        repeat (48) @(posedge sys_clk);
        #2;
        RTS = 1'b0;
        check("rts_drop_busy_held", tx_busy, 1'b1);
        wait_idle("rts_drop_frame_done");
        RTS = 1'b1;
`endif

        send(1'b0, 8'h35, "accept_35");
        wait_line(1'b0, 1'b0, acc);
        repeat (72) @(negedge sys_clk);
        check("pre_reset_bit3", TxD_ser, 1'b0);
        check("pre_reset_busy", tx_busy, 1'b1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_reset_txd", TxD_ser, 1'b1);
        check("async_reset_busy", tx_busy, 1'b0);
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        repeat (5) @(posedge sys_clk);
        send(1'b0, 8'hA5, "accept_after_reset");
        sample_frame(1'b0, 64'h34A, 10, "frame_after_reset");
        wait_idle("idle_after_reset_frame");

`ifdef UART_TX_FIFO_EN
        @(posedge sys_clk);
        #2;
        RTS = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tx_data  = 8'(8'h11 * (i + 1));
            tx_valid = 1'b1;
            @(posedge sys_clk);
            #2;
        end
        tx_valid = 1'b0;
        @(negedge sys_clk);
        check("fifo_full_ready", tx_ready, 1'b0);
        check("fifo_queued_busy", tx_busy, 1'b1);
        check("fifo_rts_low_line", TxD_ser, 1'b1);
        @(posedge sys_clk);
        #2;
        RTS = 1'b1;
        sample_frame(1'b0, {24'h0, 10'h288, 10'h266, 10'h244, 10'h222}, 40, "fifo_frames");
        wait_idle("fifo_drain_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
